depacketizer_3: RTL and testbench
=================================

# depacketizer_3

Receive-side translator that pairs with the 3-flit packetizer. It accepts NoC flits one per cycle on a ready/valid input and strips the valid, head, tail, VC and destination fields. It then reassembles the payloads of up to three flits into one data word and presents that word with its destination and VC on a registered ready/valid output. It sits between a NoC output port and a module's data input.

## Interface
- `ADDRESS_WIDTH`, 4: width of the address field carried in the head flit.
- `VC_ADDRESS_WIDTH`, 1: width of the VC field carried in every flit.
- `FLIT_WIDTH`, 12: width of one flit.
- `WIDTH_OUT`, 12: width of the reassembled data word. Must satisfy `WIDTH_OUT <= HP + 2*BP`, where `HP = FLIT_WIDTH-3-VC_ADDRESS_WIDTH-ADDRESS_WIDTH` and `BP = FLIT_WIDTH-3-VC_ADDRESS_WIDTH`.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `i_data_in`, input, FLIT_WIDTH: flit. Fields from the MSB down:
  - valid;
  - head;
  - tail;
  - vc[VC_ADDRESS_WIDTH];
  - head flit only: addr[ADDRESS_WIDTH];
  - payload (`HP` bits in a head flit, `BP` bits otherwise).
- `i_valid_in`, input, 1: flit offered.
- `i_ready_out`, output, 1: flit can be accepted.
- `o_data_out`, output, WIDTH_OUT: reassembled data.
- `o_dest_out`, output, ADDRESS_WIDTH: address field from the head flit.
- `o_vc_out`, output, VC_ADDRESS_WIDTH: VC of the head flit.
- `o_valid_out`, output, 1: output word valid.
- `o_ready_in`, input, 1: downstream accepts the output word.
- `o_error`, output, 1: one-cycle pulse on a protocol violation.

## Operation
- **Accept.** A flit is accepted when `i_valid_in & i_ready_out`.
  - An accepted flit with flit-valid bit = 0 is consumed and ignored. The state is unchanged and no error is flagged.
- **Ready.** `i_ready_out = ~o_valid_out | o_ready_in`. This is combinational, so full throughput is possible.
- **Packet body.** The payloads of consecutive flits are concatenated MSB-first into a `HP+2*BP` assembly register: flit 1 at the top, then flit 2, then flit 3.
  - `o_data_out` is the top `WIDTH_OUT` bits of that register.
  - Any flit slot not received before the tail reads as zero. The register is cleared when a head is accepted.
- **State machine.**
  - IDLE. On a valid head:
    - store addr, vc and payload 1;
    - if tail=1, complete the packet and stay in IDLE;
    - else go to F2.
  - F2. On a valid non-head flit:
    - store payload 2;
    - if tail=1, complete and go to IDLE;
    - else go to F3.
  - F3. On a valid non-head flit:
    - store payload 3;
    - complete and go to IDLE.
- **Complete.** Completing a packet loads the output register (data, dest, vc) and sets `o_valid_out`.
  - The word holds stable until `o_valid_out & o_ready_in`. `o_valid_out` then clears, unless a new completion occurs in the same cycle, in which case the new word loads and `o_valid_out` stays 1.
- **Error cases.** Each of these pulses `o_error` for one cycle:
  - Non-head valid flit in IDLE: the flit is dropped and the state stays IDLE.
  - Head flit in F2 or F3: the partial packet is discarded and the head is processed as a new packet from IDLE.
  - Non-tail flit in F3: the flit is accepted as the tail and the packet completes normally.
- **VC field of body flits.** It is not checked.

## Timing
- **Reset.** Async and immediate. State goes to IDLE and the assembly register clears. Outputs: `o_valid_out`=0, `o_data_out`=0, `o_dest_out`=0, `o_vc_out`=0, `o_error`=0. `i_ready_out`=1 once `o_valid_out`=0.
- **Reset mid-packet.** The partial packet is lost. The next packet must start with a head.
- **Latency.** A tail accepted at edge N gives `o_valid_out`=1 in the cycle after edge N; the word is registered.
- **Throughput.** One flit per cycle. A single-flit packet completes once per cycle when downstream is always ready.
- **Backpressure.** While `o_valid_out=1 & o_ready_in=0`, `i_ready_out`=0 and no flit is accepted. This stalls every state, not only the tail slot.
- **Error timing.** `o_error` is registered and asserts the cycle after the offending flit is accepted.

## Test plan
All values use default parameters.
- **2-flit packet.** Drive head `12'hC5A`, then tail `12'hABC`, in consecutive cycles, with `o_ready_in`=1. Expect `o_data_out`=12'hABC, `o_dest_out`=4'h5, `o_vc_out`=0 and `o_valid_out` high for 1 cycle, one cycle after the tail; `o_error`=0.
- **Single-flit packet.** Drive `12'hE3A` (head+tail, dest 3, payload A). Expect `o_data_out`=12'hA00 and dest 3.
- **Backpressure.** Hold `o_ready_in`=0 after the first packet completes, then offer a second packet. Expect `i_ready_out`=0 and the output word held stable. Release `o_ready_in`. Expect the second packet delivered intact, with no flit lost or duplicated.
- **Protocol errors.**
  - Body flit `12'hABC` in IDLE: one `o_error` pulse and no output.
  - Head `12'hC5A`, then head `12'hC71`, then tail `12'hA22`: one `o_error` pulse, then output 12'h122 with dest 7.
- **Invalid flits.** Insert `12'h000` flits with `i_valid_in`=1 between the head and tail. Expect the packet reassembled correctly and no error.
- **Reset mid-packet.** Assert `rst` after the head is accepted, release it, then send tail `12'hABC`. Expect an `o_error` pulse and no output; all outputs are 0 during reset.

Source files
------------

// File: rtl/depacketizer_3.sv
// Receive-side depacketizer: strips NoC flit control fields and reassembles up to
// three flit payloads into one data word on a registered ready/valid output.
module depacketizer_3 #(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int FLIT_WIDTH       = 12,
    parameter int WIDTH_OUT        = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FLIT_WIDTH-1:0]       i_data_in,
    input  logic                        i_valid_in,
    output logic                        i_ready_out,
    output logic [WIDTH_OUT-1:0]        o_data_out,
    output logic [ADDRESS_WIDTH-1:0]    o_dest_out,
    output logic [VC_ADDRESS_WIDTH-1:0] o_vc_out,
    output logic                        o_valid_out,
    input  logic                        o_ready_in,
    output logic                        o_error
);
    localparam int HP = FLIT_WIDTH - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
    localparam int BP = FLIT_WIDTH - 3 - VC_ADDRESS_WIDTH;
    localparam int AW = HP + 2 * BP;

    typedef enum logic [1:0] {IDLE, F2, F3} state_t;

    state_t                      state, state_next;
    logic [AW-1:0]               asm_p0, asm_next;
    logic [ADDRESS_WIDTH-1:0]    dest_p0, dest_next;
    logic [VC_ADDRESS_WIDTH-1:0] vc_p0, vc_next;
    logic                        complete, err_next, accept;

    logic                        flit_valid, flit_head, flit_tail;
    logic [VC_ADDRESS_WIDTH-1:0] flit_vc;
    logic [ADDRESS_WIDTH-1:0]    flit_addr;
    logic [HP-1:0]               head_pay;
    logic [BP-1:0]               body_pay;

    assign flit_valid = i_data_in[FLIT_WIDTH-1];
    assign flit_head  = i_data_in[FLIT_WIDTH-2];
    assign flit_tail  = i_data_in[FLIT_WIDTH-3];
    assign flit_vc    = i_data_in[FLIT_WIDTH-4 -: VC_ADDRESS_WIDTH];
    assign flit_addr  = i_data_in[FLIT_WIDTH-4-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH];
    assign head_pay   = i_data_in[HP-1:0];
    assign body_pay   = i_data_in[BP-1:0];

    assign i_ready_out = ~o_valid_out | o_ready_in;
    assign accept      = i_valid_in & i_ready_out;

    always_comb begin
        state_next = state;
        asm_next   = asm_p0;
        dest_next  = dest_p0;
        vc_next    = vc_p0;
        complete   = 1'b0;
        err_next   = 1'b0;
        if (accept && flit_valid) begin
            if (flit_head) begin
                // A head in mid-packet abandons the partial packet and restarts.
                err_next   = (state != IDLE);
                asm_next   = {head_pay, {(2*BP){1'b0}}};
                dest_next  = flit_addr;
                vc_next    = flit_vc;
                complete   = flit_tail;
                state_next = flit_tail ? IDLE : F2;
            end else begin
                case (state)
                    IDLE: err_next = 1'b1;
                    F2: begin
                        asm_next[2*BP-1:BP] = body_pay;
                        complete   = flit_tail;
                        state_next = flit_tail ? IDLE : F3;
                    end
                    F3: begin
                        // Third slot always terminates the packet, tail bit or not.
                        asm_next[BP-1:0] = body_pay;
                        err_next   = ~flit_tail;
                        complete   = 1'b1;
                        state_next = IDLE;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Stage p0: assembly state; output registers load on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            asm_p0      <= '0;
            dest_p0     <= '0;
            vc_p0       <= '0;
            o_data_out  <= '0;
            o_dest_out  <= '0;
            o_vc_out    <= '0;
            o_valid_out <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            state   <= state_next;
            asm_p0  <= asm_next;
            dest_p0 <= dest_next;
            vc_p0   <= vc_next;
            o_error <= err_next;
            if (complete) begin
                o_data_out  <= asm_next[AW-1 -: WIDTH_OUT];
                o_dest_out  <= dest_next;
                o_vc_out    <= vc_next;
                o_valid_out <= 1'b1;
            end else if (o_ready_in) begin
                o_valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_depacketizer_3.sv
// Directed self-checking bench for depacketizer_3 with default parameters.
module tb_depacketizer_3;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] i_data_in = '0;
    logic        i_valid_in = 1'b0;
    logic        i_ready_out;
    logic [11:0] o_data_out;
    logic [3:0]  o_dest_out;
    logic [0:0]  o_vc_out;
    logic        o_valid_out;
    logic        o_ready_in = 1'b1;
    logic        o_error;

    int n_checks = 0;
    int n_fail   = 0;
    int out_cnt  = 0;
    int err_cnt  = 0;
    logic [11:0] last_data = '0;
    logic [3:0]  last_dest = '0;

    depacketizer_3 dut (
        .clk(clk), .rst(rst), .i_data_in(i_data_in), .i_valid_in(i_valid_in),
        .i_ready_out(i_ready_out), .o_data_out(o_data_out), .o_dest_out(o_dest_out),
        .o_vc_out(o_vc_out), .o_valid_out(o_valid_out), .o_ready_in(o_ready_in),
        .o_error(o_error)
    );

    always #5 clk = ~clk;

    // Record delivered words and error pulses away from the active edge.
    always @(negedge clk) begin
        if (o_valid_out && o_ready_in) begin
            out_cnt   <= out_cnt + 1;
            last_data <= o_data_out;
            last_dest <= o_dest_out;
        end
        if (o_error) err_cnt <= err_cnt + 1;
    end

    task automatic drive(input logic [11:0] f);
        int waited = 0;
        i_data_in  = f;
        i_valid_in = 1'b1;
        @(negedge clk);
        while (!i_ready_out && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        n_checks++;
        if (i_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL drive_timeout flit=%h ready=%b required 1", f, i_ready_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_valid_in = 1'b0;
        i_data_in  = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks += 6;
        if (o_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", o_valid_out); end
        if (o_data_out !== 12'h000) begin n_fail++; $display("FAIL rst_data got %h want 000", o_data_out); end
        if (o_dest_out !== 4'h0) begin n_fail++; $display("FAIL rst_dest got %h want 0", o_dest_out); end
        if (o_vc_out !== 1'b0) begin n_fail++; $display("FAIL rst_vc got %b want 0", o_vc_out); end
        if (o_error !== 1'b0) begin n_fail++; $display("FAIL rst_error got %b want 0", o_error); end
        if (i_ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", i_ready_out); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_two_flit();
        int o0 = out_cnt, e0 = err_cnt;
        drive(12'hC5A);
        drive(12'hABC);
        i_valid_in = 1'b0;
        n_checks += 4;
        if (o_valid_out !== 1'b1) begin n_fail++; $display("FAIL two_valid got %b want 1", o_valid_out); end
        if (o_data_out !== 12'hABC) begin n_fail++; $display("FAIL two_data got %h want abc", o_data_out); end
        if (o_dest_out !== 4'h5) begin n_fail++; $display("FAIL two_dest got %h want 5", o_dest_out); end
        if (o_vc_out !== 1'b0) begin n_fail++; $display("FAIL two_vc got %b want 0", o_vc_out); end
        @(posedge clk);
        #1;
        n_checks++;
        if (o_valid_out !== 1'b0) begin n_fail++; $display("FAIL two_valid_drop got %b want 0", o_valid_out); end
        idle(2);
        n_checks += 2;
        if (out_cnt - o0 !== 1) begin n_fail++; $display("FAIL two_count got %0d want 1", out_cnt - o0); end
        if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL two_err got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_single_flit();
        int o0;
        drive(12'hE3A);
        i_valid_in = 1'b0;
        n_checks += 3;
        if (o_data_out !== 12'hA00) begin n_fail++; $display("FAIL single_data got %h want a00", o_data_out); end
        if (o_dest_out !== 4'h3) begin n_fail++; $display("FAIL single_dest got %h want 3", o_dest_out); end
        if (o_valid_out !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", o_valid_out); end
        idle(2);
        o0 = out_cnt;
        drive(12'hE3A);
        drive(12'hE5B);
        drive(12'hE7C);
        idle(3);
        n_checks += 3;
        if (out_cnt - o0 !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", out_cnt - o0); end
        if (last_data !== 12'hC00) begin n_fail++; $display("FAIL b2b_data got %h want c00", last_data); end
        if (last_dest !== 4'h7) begin n_fail++; $display("FAIL b2b_dest got %h want 7", last_dest); end
    endtask

    task automatic test_backpressure();
        int o0 = out_cnt;
        o_ready_in = 1'b0;
        drive(12'hC5A);
        drive(12'hABC);
        i_data_in  = 12'hC71;
        i_valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks += 3;
            if (i_ready_out !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc%0d got %b want 0", k, i_ready_out); end
            if (o_valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc%0d got %b want 1", k, o_valid_out); end
            if (o_data_out !== 12'hABC) begin n_fail++; $display("FAIL bp_hold cyc%0d got %h want abc", k, o_data_out); end
        end
        @(posedge clk);
        #1;
        o_ready_in = 1'b1;
        drive(12'hC71);
        drive(12'hA22);
        i_valid_in = 1'b0;
        n_checks += 2;
        if (o_data_out !== 12'h122) begin n_fail++; $display("FAIL bp_data2 got %h want 122", o_data_out); end
        if (o_dest_out !== 4'h7) begin n_fail++; $display("FAIL bp_dest2 got %h want 7", o_dest_out); end
        idle(3);
        n_checks++;
        if (out_cnt - o0 !== 2) begin n_fail++; $display("FAIL bp_count got %0d want 2", out_cnt - o0); end
    endtask

    task automatic test_protocol_errors();
        int o0 = out_cnt, e0 = err_cnt;
        drive(12'hABC);
        idle(3);
        n_checks += 2;
        if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL idle_body_err got %0d want 1", err_cnt - e0); end
        if (out_cnt - o0 !== 0) begin n_fail++; $display("FAIL idle_body_out got %0d want 0", out_cnt - o0); end
        o0 = out_cnt; e0 = err_cnt;
        drive(12'hC5A);
        drive(12'hC71);
        drive(12'hA22);
        idle(3);
        n_checks += 4;
        if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL rehead_err got %0d want 1", err_cnt - e0); end
        if (out_cnt - o0 !== 1) begin n_fail++; $display("FAIL rehead_out got %0d want 1", out_cnt - o0); end
        if (last_data !== 12'h122) begin n_fail++; $display("FAIL rehead_data got %h want 122", last_data); end
        if (last_dest !== 4'h7) begin n_fail++; $display("FAIL rehead_dest got %h want 7", last_dest); end
        o0 = out_cnt; e0 = err_cnt;
        drive(12'hC5A);
        drive(12'h8BC);
        drive(12'h811);
        idle(3);
        n_checks += 3;
        if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL f3_err got %0d want 1", err_cnt - e0); end
        if (out_cnt - o0 !== 1) begin n_fail++; $display("FAIL f3_out got %0d want 1", out_cnt - o0); end
        if (last_data !== 12'hABC) begin n_fail++; $display("FAIL f3_data got %h want abc", last_data); end
    endtask

    task automatic test_invalid_flits();
        int o0 = out_cnt, e0 = err_cnt;
        drive(12'hC5A);
        drive(12'h000);
        drive(12'h000);
        drive(12'hABC);
        idle(3);
        n_checks += 4;
        if (out_cnt - o0 !== 1) begin n_fail++; $display("FAIL inv_out got %0d want 1", out_cnt - o0); end
        if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL inv_err got %0d want 0", err_cnt - e0); end
        if (last_data !== 12'hABC) begin n_fail++; $display("FAIL inv_data got %h want abc", last_data); end
        if (last_dest !== 4'h5) begin n_fail++; $display("FAIL inv_dest got %h want 5", last_dest); end
    endtask

    task automatic test_reset_mid_packet();
        int o0, e0;
        drive(12'hC5A);
        i_valid_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (o_valid_out !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", o_valid_out); end
        if (o_data_out !== 12'h000) begin n_fail++; $display("FAIL midrst_data got %h want 000", o_data_out); end
        if (o_dest_out !== 4'h0) begin n_fail++; $display("FAIL midrst_dest got %h want 0", o_dest_out); end
        if (o_error !== 1'b0) begin n_fail++; $display("FAIL midrst_error got %b want 0", o_error); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        o0 = out_cnt; e0 = err_cnt;
        drive(12'hABC);
        idle(3);
        n_checks += 2;
        if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL midrst_tail_err got %0d want 1", err_cnt - e0); end
        if (out_cnt - o0 !== 0) begin n_fail++; $display("FAIL midrst_tail_out got %0d want 0", out_cnt - o0); end
    endtask

    initial begin
        test_reset();
        test_two_flit();
        test_single_flit();
        test_backpressure();
        test_protocol_errors();
        test_invalid_flits();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
